// File: rtl/uart_reg_bridge.sv
// Host command responder: parses 0x55-framed read/write packets from the UART
// receive stream, drives a 32-bit register bus and returns the response bytes.
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT = 5_000_000
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxSend,
  input  logic        ipTxBusy,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  output logic        opRdEnable,
  input  logic [31:0] ipRdData
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] RESP_OK   = 8'hAA;
  localparam logic [7:0] RESP_ERR  = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_CMD, S_GET_ADDR, S_GET_DATA,
    S_WRITE, S_READ, S_READ_WAIT, S_SEND, S_WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          is_write_q, is_write_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [39:0]   resp_q, resp_d;
  logic [2:0]    resp_len_q, resp_len_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      byte_cnt_q <= '0;
      resp_q     <= '0;
      resp_len_q <= '0;
      tx_idx_q   <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      byte_cnt_q <= byte_cnt_d;
      resp_q     <= resp_d;
      resp_len_q <= resp_len_d;
      tx_idx_q   <= tx_idx_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    byte_cnt_d = byte_cnt_q;
    resp_d     = resp_q;
    resp_len_d = resp_len_q;
    tx_idx_d   = tx_idx_q;
    tmo_d      = '0;

    case (state_q)
      S_IDLE: begin
        tx_idx_d = '0;
        if (ipRxValid && ipRxData == SYNC_BYTE) state_d = S_GET_CMD;
      end

      S_GET_CMD, S_GET_ADDR, S_GET_DATA: begin
        // An expiring gap abandons the packet even if a byte lands this cycle.
        if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else if (!ipRxValid) begin
          tmo_d = tmo_q + 1'b1;
        end else begin
          case (state_q)
            S_GET_CMD: begin
              if (ipRxData == 8'h00 || ipRxData == 8'h01) begin
                is_write_d = ipRxData[0];
                state_d    = S_GET_ADDR;
              end else begin
                resp_d     = {32'h0, RESP_ERR};
                resp_len_d = 3'd1;
                state_d    = S_SEND;
              end
            end
            S_GET_ADDR: begin
              addr_d     = ipRxData;
              byte_cnt_d = '0;
              state_d    = is_write_q ? S_GET_DATA : S_READ;
            end
            default: begin
              wr_data_d[{byte_cnt_q, 3'b000} +: 8] = ipRxData;
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) state_d = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        resp_d     = {32'h0, RESP_OK};
        resp_len_d = 3'd1;
        state_d    = S_SEND;
      end

      S_READ: state_d = S_READ_WAIT;

      S_READ_WAIT: begin
        resp_d     = {ipRdData, RESP_OK};
        resp_len_d = 3'd5;
        state_d    = S_SEND;
      end

      S_SEND: begin
        if (ipTxBusy) state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (!ipTxBusy) begin
          tx_idx_d = tx_idx_q + 3'd1;
          state_d  = (tx_idx_q + 3'd1 < resp_len_q) ? S_SEND : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign opAddress  = addr_q;
  assign opWrData   = wr_data_q;
  assign opWrEnable = (state_q == S_WRITE);
  assign opRdEnable = (state_q == S_READ);
  assign opTxSend   = (state_q == S_SEND);
  // The byte stays on the bus through WaitDone so the UART can re-sample it.
  assign opTxData   = (state_q == S_SEND || state_q == S_WAIT_DONE)
                      ? resp_q[{tx_idx_q, 3'b000} +: 8] : 8'h00;

endmodule
